citadel_uart: RTL and testbench
===============================

Name: citadel_uart

Overview:
- 8N1 asynchronous serial transceiver used as peripheral uart0 of the citadel SoC.
- The bus glue writes a byte to transmit with a one-cycle strobe and reads the received byte from a 32-bit word.
- An empty receive buffer reads back as all-ones (32'hFFFF_FFFF); the glue uses this as its "data available" flag.
- A busy flag tells the glue when the transmitter cannot accept a byte.

Parameters:
- CLKS_PER_BIT, 868: r_clk cycles per serial bit (100 MHz / 115200); minimum 4.
- RX_FIFO_DEPTH, 16: receive FIFO entries, power of two; used only when UART_RX_FIFO_EN is defined.

Ports:
- r_clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- we  in  1  one-cycle strobe: transmit so[7:0]
- re  in  1  one-cycle strobe: consume the current received byte
- so  in  32  transmit word; only bits [7:0] are used
- si  out  32  received word: {24'h0, byte} when data is available, else 32'hFFFF_FFFF
- wa  out  1  transmitter busy

Behaviour:
- Reset (rst_n low at a r_clk edge): tx=1, wa=0, si=32'hFFFF_FFFF, both FSMs idle, RX buffer empty, all counters 0.
- Framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states and transitions: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - A we seen in IDLE latches so[7:0].
  - On the next edge: wa=1 and tx=0 (start bit).
  - wa stays 1 through the complete stop bit, then returns to 0 in IDLE.
  - A we while wa=1 is ignored. so[31:8] is ignored.
- RX input: rx passes through a 2-FF synchronizer.
- RX FSM states and transitions: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - A falling edge in IDLE starts START.
  - The start bit is re-sampled at CLKS_PER_BIT/2. If it is high there: false start, return to IDLE.
  - Data and stop bits are sampled at the middle of each bit.
  - Stop bit = 1: the byte is pushed into the RX buffer.
  - Stop bit = 0 (framing error): the byte is discarded, and the FSM waits for rx=1 before returning to IDLE.
- RX buffer (default, no FIFO): single holding register plus a valid bit.
  - si is combinational from the holding register: {24'h0, data} if valid, else all-ones.
  - re pops on the clock edge: valid=0 from the next cycle. re while empty has no effect.
  - Overrun: a new byte overwrites the held byte, and valid stays 1.
  - re and byte completion in the same cycle: the new byte wins (valid=1, new data).
- TX and RX are fully independent; full-duplex operation is required.
- Reset asserted mid-frame: both FSMs abort, tx goes to 1 immediately on that edge, and the buffer is emptied.
- Byte 8'hFF is distinguishable from empty: 32'h0000_00FF vs 32'hFFFF_FFFF.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- When defined, the holding register is replaced by an RX_FIFO_DEPTH-entry FIFO:
  - si shows the head entry (all-ones when the FIFO is empty); re pops the head.
  - A byte arriving while the FIFO is full is dropped. Stored contents are not modified.
  - Simultaneous push and pop on a full FIFO both succeed.
- When undefined: single-entry overwrite behaviour as above.

Decomposition:
- Package citadel_uart_pkg:
  - constants DATA_BITS=8 and RX_EMPTY_WORD=32'hFFFF_FFFF;
  - enum typedefs for the TX and RX FSM states (IDLE, START, DATA, STOP).
- One sub-module: citadel_uart_rx. It contains the synchronizer, RX FSM and bit counter, and outputs a one-cycle byte_valid with byte_data.
- The TX FSM and RX buffer/FIFO live in the top module.

Test Plan (CLKS_PER_BIT=4):
- Reset, then idle -> tx=1, wa=0, si=32'hFFFF_FFFF.
- TX: we=1 with so=32'h1234_00A5 -> next cycle wa=1; tx shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; wa=0 after 40 cycles; a second we at cycle 10 is ignored.
- RX: drive frame 0x3C on rx -> si=32'h0000_003C about 2 cycles after stop-bit mid-sample; pulse re -> si=32'hFFFF_FFFF next cycle.
- Edge cases:
  - RX 0xFF -> si=32'h0000_00FF.
  - Framing error on 0x55 (stop bit 0) -> si stays all-ones.
  - 2-cycle low glitch on rx -> no byte received.
- Overrun: receive 0x11 then 0x22 without re -> si=32'h0000_0022. With UART_RX_FIFO_EN, the same stimulus gives 0x11, then 0x22 after re.
- Full duplex: TX 0x81 while RX 0x7E arrives; assert rst_n=0 mid-TX -> tx=1, wa=0, si all-ones on that edge.

Source files
------------

// File: rtl/citadel_uart_pkg.sv
// ============================================================================
//  Module   : citadel_uart_pkg
//  Purpose  : Shared constants and FSM state encodings for the uart0 peripheral.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package citadel_uart_pkg;

    localparam int          DATA_BITS     = 8;
    localparam int          BIT_IDX_W     = $clog2(DATA_BITS);
    localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/citadel_uart_rx.sv
// ============================================================================
//  Module   : citadel_uart_rx
//  Purpose  : 8N1 receiver: input synchronizer, mid-bit sampling FSM, one-cycle
//             byte strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module citadel_uart_rx
    import citadel_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 r_clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    output logic                 o_byte_valid,
    output logic [DATA_BITS-1:0] o_byte_data
);

    localparam int             CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] c_LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync3;
    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_IDX_W-1:0] r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_valid;

    rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_IDX_W-1:0] w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_ferr_nxt;
    logic                 w_valid_nxt;

    // r_sync3 only delays the synchronized line for falling-edge detection.
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_ferr  <= w_ferr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_ferr_nxt  = r_ferr;
        w_valid_nxt = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt  = '0;
                w_ferr_nxt = 1'b0;
                if (!r_sync2 && r_sync3) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
                    if (r_bit == c_LAST_BIT) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                // After a bad stop bit, hold here until the line idles high.
                if (r_ferr) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_state_nxt = RX_IDLE;
                    end
                end else if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign o_byte_valid = r_valid;
    assign o_byte_data  = r_shift;

endmodule

`default_nettype wire

// File: rtl/citadel_uart.sv
// ============================================================================
//  Module   : citadel_uart
//  Purpose  : 8N1 UART (uart0): TX FSM plus RX buffer. Define UART_RX_FIFO_EN
//             to replace the single holding register with an RX FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module citadel_uart
    import citadel_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        r_clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] so,
    output logic [31:0] si,
    output logic        wa
);

    localparam int                   CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     c_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] c_LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t            r_tx_state;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [BIT_IDX_W-1:0] r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx;

    tx_state_t            w_tx_state_nxt;
    logic [CNT_W-1:0]     w_tx_cnt_nxt;
    logic [BIT_IDX_W-1:0] w_tx_bit_nxt;
    logic [DATA_BITS-1:0] w_tx_shift_nxt;
    logic                 w_tx_nxt;

    logic                 w_byte_valid;
    logic [DATA_BITS-1:0] w_byte_data;
    logic [23:0]          w_unused_so;

    assign w_unused_so = so[31:8];

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // The line level is registered alongside the state so tx never glitches.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_nxt       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_nxt     = 1'b1;
                if (we) begin
                    w_tx_shift_nxt = so[DATA_BITS-1:0];
                    w_tx_state_nxt = TX_START;
                    w_tx_nxt       = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                    w_tx_nxt       = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == c_LAST_BIT) begin
                        w_tx_state_nxt = TX_STOP;
                        w_tx_nxt       = 1'b1;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 1'b1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        w_tx_nxt       = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_nxt       = 1'b1;
            end
        endcase
    end

    assign tx = r_tx;
    assign wa = (r_tx_state != TX_IDLE);

    citadel_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .r_clk        (r_clk),
        .rst_n        (rst_n),
        .i_rx         (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data)
    );

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0] c_FIFO_FULL = (PTR_W + 1)'(RX_FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FIFO_FULL);
    assign w_pop   = re && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_byte_valid && (!w_full || w_pop);

    always_ff @(posedge r_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_byte_data;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign si = w_empty ? RX_EMPTY_WORD : {24'h0, r_fifo_mem[r_rd_ptr]};
`else
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic [31:0]          w_unused_depth;

    assign w_unused_depth = RX_FIFO_DEPTH;

    // A completing byte takes priority over a same-cycle pop (overrun keeps newest).
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_byte_valid) begin
            r_rx_data  <= w_byte_data;
            r_rx_valid <= 1'b1;
        end else if (re) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign si = r_rx_valid ? {24'h0, r_rx_data} : RX_EMPTY_WORD;
`endif

endmodule

`default_nettype wire

// File: tb/tb_citadel_uart.sv
// ============================================================================
//  Module   : tb_citadel_uart
//  Purpose  : Self-checking bench for citadel_uart with CLKS_PER_BIT=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_citadel_uart;

    localparam int          CPB   = 4;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    logic        r_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [31:0] so    = 32'h0;
    logic        tx;
    logic        wa;
    logic [31:0] si;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  rx_q[$];

    citadel_uart #(
        .CLKS_PER_BIT  (CPB),
        .RX_FIFO_DEPTH (4)
    ) dut (
        .r_clk (r_clk),
        .rst_n (rst_n),
        .rx    (rx),
        .tx    (tx),
        .we    (we),
        .re    (re),
        .so    (so),
        .si    (si),
        .wa    (wa)
    );

    always #5 r_clk = ~r_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge r_clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (CPB) tick();
    endtask

    // Pop the scoreboard head when si shows data, then consume it with re.
    task automatic rx_expect(input string name);
        int          budget;
        logic [7:0]  exp_b;
        logic [31:0] exp_after;
        budget = 40;
        while (si === EMPTY && budget > 0) begin
            tick();
            budget--;
        end
        n_checks++;
        if (rx_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: si=%h but no byte expected", name, si);
        end else begin
            exp_b = rx_q.pop_front();
            if (si !== {24'h0, exp_b}) begin
                n_errors++;
                $display("FAIL %s: si=%h expected %h", name, si, {24'h0, exp_b});
            end
        end
        exp_after = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : EMPTY;
        re = 1'b1;
        tick();
        re = 1'b0;
        n_checks++;
        if (si !== exp_after) begin
            n_errors++;
            $display("FAIL %s_after_re: si=%h expected %h", name, si, exp_after);
        end
    endtask

    task automatic check_empty(input string name);
        n_checks++;
        if (si !== EMPTY) begin
            n_errors++;
            $display("FAIL %s: si=%h expected %h", name, si, EMPTY);
        end
    endtask

    task automatic test_tx(input logic [31:0] word, input bit try_ignore);
        logic exp_q[$];
        logic exp_bit;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(word[i]);
        exp_q.push_back(1'b1);
        so = word;
        we = 1'b1;
        tick();
        we = 1'b0;
        n_checks++;
        if (wa !== 1'b1) begin
            n_errors++;
            $display("FAIL tx_wa_start: wa=%b expected 1", wa);
        end
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 1) begin
                exp_bit = exp_q.pop_front();
                n_checks++;
                if (tx !== exp_bit) begin
                    n_errors++;
                    $display("FAIL tx_bit%0d: tx=%b expected %b", c / 4, tx, exp_bit);
                end
            end
            if (c == 10 && try_ignore) begin
                so = 32'h0000_005A;
                we = 1'b1;
            end
            if (c == 11) we = 1'b0;
            if (c == 39) begin
                n_checks++;
                if (wa !== 1'b1) begin
                    n_errors++;
                    $display("FAIL tx_wa_stop: wa=%b expected 1", wa);
                end
            end
            tick();
        end
        repeat (3) begin
            n_checks++;
            if (wa !== 1'b0 || tx !== 1'b1) begin
                n_errors++;
                $display("FAIL tx_done: wa=%b tx=%b expected wa=0 tx=1", wa, tx);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        n_checks++;
        if (wa !== 1'b0) begin n_errors++; $display("FAIL reset_wa: wa=%b expected 0", wa); end
        check_empty("reset_si");
    endtask

    task automatic test_rx_basic();
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        rx_expect("rx_3c");
        rx_q.push_back(8'hFF);
        send_rx(8'hFF, 1'b1);
        rx_expect("rx_ff");
    endtask

    task automatic test_framing();
        send_rx(8'h55, 1'b0);
        repeat (8) tick();
        check_empty("framing_err");
        rx_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        rx_expect("rx_after_ferr");
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (12) tick();
        check_empty("glitch");
        rx_q.push_back(8'hA7);
        send_rx(8'hA7, 1'b1);
        rx_expect("rx_after_glitch");
    endtask

    task automatic test_overrun();
`ifdef UART_RX_FIFO_EN
        rx_q.push_back(8'h11);
`endif
        rx_q.push_back(8'h22);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        while (rx_q.size() > 0) rx_expect("overrun");
    endtask

    task automatic test_full_duplex();
        rx_q.push_back(8'h7E);
        fork
            send_rx(8'h7E, 1'b1);
            test_tx(32'h0000_0081, 1'b0);
        join
        rx_expect("duplex_rx");
    endtask

    task automatic test_reset_mid();
        int budget;
        rx_q.push_back(8'h99);
        send_rx(8'h99, 1'b1);
        budget = 40;
        while (si === EMPTY && budget > 0) begin
            tick();
            budget--;
        end
        n_checks++;
        if (si !== {24'h0, rx_q[0]}) begin
            n_errors++;
            $display("FAIL pre_reset_si: si=%h expected %h", si, {24'h0, rx_q[0]});
        end
        rx_q.delete();
        so = 32'h0000_00C3;
        we = 1'b1;
        tick();
        we = 1'b0;
        repeat (14) tick();
        n_checks++;
        if (wa !== 1'b1 || tx !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_reset_tx: wa=%b tx=%b expected wa=1 tx=0", wa, tx);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL midreset_tx: tx=%b expected 1", tx); end
        n_checks++;
        if (wa !== 1'b0) begin n_errors++; $display("FAIL midreset_wa: wa=%b expected 0", wa); end
        check_empty("midreset_si");
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_tx(32'h1234_00A5, 1'b1);
        test_rx_basic();
        test_framing();
        test_glitch();
        test_overrun();
        test_full_duplex();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
